// File: rtl/cfg_reg_pkg.sv
// Shared defaults and helpers for the configuration register bank.
package cfg_reg_pkg;

   localparam int unsigned DEF_NUM_REGS = 64;
   localparam int unsigned DEF_DATA_W   = 8;
   localparam int unsigned DEF_ADDR_W   = 6;
   localparam int unsigned DEF_LOCK_BIT = 0;

   // The lock register defaults to the top of the bank.
   function automatic int unsigned def_lock_addr(input int unsigned num_regs);
      return num_regs - 1;
   endfunction

   // Bit offset of register n inside a flat NUM_REGS*DATA_W image.
   function automatic int unsigned reg_slice(input int unsigned n,
                                             input int unsigned w = DEF_DATA_W);
      return n * w;
   endfunction

endpackage

// File: rtl/cfg_reg_cell.sv
// One configuration register: staged copy, active copy and dirty flag.
// CFG_PARITY_EN adds an even-parity bit on the active copy with a sticky mismatch flag.
module cfg_reg_cell #(
   parameter int unsigned         DATA_W    = 8,
   parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
   input  logic              SCK,
   input  logic              NRST,
   input  logic              i_stage_wr,
   input  logic              i_direct_wr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_commit,
   input  logic              i_abort,
   output logic [DATA_W-1:0] o_stage,
   output logic [DATA_W-1:0] o_active,
   output logic              o_dirty,
   output logic              o_parity_err
);

   logic [DATA_W-1:0] r_stage, r_active;
   logic              r_dirty;
   logic [DATA_W-1:0] w_stage_d, w_active_d;
   logic              w_dirty_d;

   // Abort outranks commit; a same-cycle write is applied on top of either.
   always_comb begin
      w_stage_d  = r_stage;
      w_active_d = r_active;
      w_dirty_d  = r_dirty;
      if (i_abort) begin
         w_stage_d = r_active;
         w_dirty_d = 1'b0;
      end else if (i_commit) begin
         if (r_dirty) begin
            w_active_d = r_stage;
         end
         w_dirty_d = 1'b0;
      end
      if (i_stage_wr) begin
         w_stage_d = i_wdata;
         w_dirty_d = 1'b1;
      end
      if (i_direct_wr) begin
         w_stage_d  = i_wdata;
         w_active_d = i_wdata;
      end
   end

   always_ff @(posedge SCK or negedge NRST) begin
      if (!NRST) begin
         r_stage  <= RESET_VAL;
         r_active <= RESET_VAL;
         r_dirty  <= 1'b0;
      end else begin
         r_stage  <= w_stage_d;
         r_active <= w_active_d;
         r_dirty  <= w_dirty_d;
      end
   end

`ifdef CFG_PARITY_EN
   logic r_par, r_perr;

   always_ff @(posedge SCK or negedge NRST) begin
      if (!NRST) begin
         r_par  <= ^RESET_VAL;
         r_perr <= 1'b0;
      end else begin
         // Parity is only rewritten when the active value actually changes,
         // so a corrupted bit keeps mismatching the stored parity.
         if (w_active_d != r_active) begin
            r_par <= ^w_active_d;
         end
         if ((^r_active) != r_par) begin
            r_perr <= 1'b1;
         end
      end
   end

   assign o_parity_err = r_perr;
`else
   assign o_parity_err = 1'b0;
`endif

   assign o_stage  = r_stage;
   assign o_active = r_active;
   assign o_dirty  = r_dirty;

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register bank: staged writes with atomic commit/abort, read-only mask,
// write lock and registered readback. Optional CFG_PARITY_EN enables active-copy parity.
module cfg_reg_bank
   import cfg_reg_pkg::*;
#(
   parameter int unsigned                    NUM_REGS  = DEF_NUM_REGS,
   parameter int unsigned                    DATA_W    = DEF_DATA_W,
   parameter int unsigned                    ADDR_W    = DEF_ADDR_W,
   parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = '0,
   parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
   parameter bit                             IMMEDIATE = 1'b0,
   parameter int unsigned                    LOCK_ADDR = def_lock_addr(NUM_REGS),
   parameter int unsigned                    LOCK_BIT  = DEF_LOCK_BIT
) (
   input  logic                         SCK,
   input  logic                         NRST,
   input  logic [ADDR_W-1:0]            reg_addr,
   input  logic [DATA_W-1:0]            reg_value,
   input  logic                         wr_en,
   input  logic                         commit,
   input  logic                         abort,
   input  logic [ADDR_W-1:0]            rd_addr,
   input  logic                         rd_stage,
   output logic [DATA_W-1:0]            rd_data,
   output logic [NUM_REGS*DATA_W-1:0]   cfg_data,
   output logic                         pending,
   output logic                         wr_err,
   output logic                         parity_err
);

   logic [DATA_W-1:0]   w_stage  [NUM_REGS];
   logic [DATA_W-1:0]   w_active [NUM_REGS];
   logic [NUM_REGS-1:0] w_sel, w_dirty, w_perr, w_stage_wr, w_direct_wr;
   logic                w_addr_ok, w_ro, w_lock, w_is_lock, w_accept;
   logic                w_commit, w_abort;
   logic [DATA_W-1:0]   w_rd_val;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_wr_err;

   // An out-of-range address matches no select line, so it is rejected like a RO hit.
   assign w_addr_ok = |w_sel;
   assign w_ro      = |(w_sel & RO_MASK);
   assign w_is_lock = w_sel[LOCK_ADDR];
   assign w_lock    = w_active[LOCK_ADDR][LOCK_BIT];
   assign w_accept  = wr_en && w_addr_ok && !w_ro && (!w_lock || w_is_lock);

   assign w_commit  = commit && !IMMEDIATE;
   assign w_abort   = abort && !IMMEDIATE;

   genvar n;
   generate
      for (n = 0; n < NUM_REGS; n++) begin : g_cell
         localparam bit LOCK_CELL = (n == LOCK_ADDR);

         assign w_sel[n]       = (reg_addr == ADDR_W'(n));
         assign w_stage_wr[n]  = w_accept && w_sel[n] && !IMMEDIATE && !LOCK_CELL;
         assign w_direct_wr[n] = w_accept && w_sel[n] && (IMMEDIATE || LOCK_CELL);

         cfg_reg_cell #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL[reg_slice(n, DATA_W) +: DATA_W])
         ) u_cell (
            .SCK          (SCK),
            .NRST         (NRST),
            .i_stage_wr   (w_stage_wr[n]),
            .i_direct_wr  (w_direct_wr[n]),
            .i_wdata      (reg_value),
            .i_commit     (w_commit),
            .i_abort      (w_abort),
            .o_stage      (w_stage[n]),
            .o_active     (w_active[n]),
            .o_dirty      (w_dirty[n]),
            .o_parity_err (w_perr[n])
         );

         assign cfg_data[reg_slice(n, DATA_W) +: DATA_W] = w_active[n];
      end
   endgenerate

   always_comb begin
      w_rd_val = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == ADDR_W'(i)) begin
            w_rd_val = rd_stage ? w_stage[i] : w_active[i];
         end
      end
   end

   always_ff @(posedge SCK or negedge NRST) begin
      if (!NRST) begin
         r_rd_data <= '0;
         r_wr_err  <= 1'b0;
      end else begin
         r_rd_data <= w_rd_val;
         r_wr_err  <= wr_en && !w_accept;
      end
   end

   assign rd_data    = r_rd_data;
   assign wr_err     = r_wr_err;
   assign pending    = |w_dirty;
   assign parity_err = |w_perr;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Self-checking bench for cfg_reg_bank: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_cfg_reg_bank;

   localparam int unsigned NR = 48;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 6;
   localparam int unsigned LA = NR - 1;
   localparam int unsigned IW = NR * DW;

   function automatic logic [IW-1:0] mk_reset();
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < NR; i++) r[i*DW +: DW] = 8'((i * 7 + 3) % 256);
      return r;
   endfunction

   localparam logic [IW-1:0] RV = mk_reset();
   localparam logic [NR-1:0] RO = 48'h0000_0000_0020;

   logic          SCK = 1'b0;
   logic          NRST;
   logic [AW-1:0] reg_addr, rd_addr;
   logic [DW-1:0] reg_value;
   logic          wr_en, commit, abort, rd_stage;
   logic [DW-1:0] rd_data;
   logic [IW-1:0] cfg_data;
   logic          pending, wr_err, parity_err;

   cfg_reg_bank #(
      .NUM_REGS  (NR),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .RESET_VAL (RV),
      .RO_MASK   (RO),
      .IMMEDIATE (1'b0),
      .LOCK_ADDR (LA),
      .LOCK_BIT  (0)
   ) dut (
      .SCK        (SCK),
      .NRST       (NRST),
      .reg_addr   (reg_addr),
      .reg_value  (reg_value),
      .wr_en      (wr_en),
      .commit     (commit),
      .abort      (abort),
      .rd_addr    (rd_addr),
      .rd_stage   (rd_stage),
      .rd_data    (rd_data),
      .cfg_data   (cfg_data),
      .pending    (pending),
      .wr_err     (wr_err),
      .parity_err (parity_err)
   );

   always #5 SCK = ~SCK;

   logic [DW-1:0] m_act [NR];
   logic [DW-1:0] m_stg [NR];
   bit            m_dirty [NR];
   int            n_tests = 0;
   int            n_fail  = 0;

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) begin
         m_act[i]   = RV[i*DW +: DW];
         m_stg[i]   = RV[i*DW +: DW];
         m_dirty[i] = 1'b0;
      end
   endfunction

   function automatic logic [IW-1:0] model_image();
      logic [IW-1:0] r;
      for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_act[i];
      return r;
   endfunction

   function automatic bit model_pending();
      bit p = 1'b0;
      for (int i = 0; i < NR; i++) p |= m_dirty[i];
      return p;
   endfunction

   task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One SCK cycle: drive inputs, advance the model by the behavioural rules, check after the edge.
   task automatic step(input bit we, input int a, input logic [DW-1:0] v, input bit cm,
                       input bit ab, input int ra, input bit rs);
      bit            acc;
      logic [DW-1:0] erd;
      wr_en     = we;
      reg_addr  = AW'(a);
      reg_value = v;
      commit    = cm;
      abort     = ab;
      rd_addr   = AW'(ra);
      rd_stage  = rs;
      erd = (ra < NR) ? (rs ? m_stg[ra] : m_act[ra]) : 8'h00;
      acc = we && (a < NR) && !RO[a] && (!m_act[LA][0] || a == LA);
      if (ab) begin
         for (int i = 0; i < NR; i++) begin
            m_stg[i]   = m_act[i];
            m_dirty[i] = 1'b0;
         end
      end else if (cm) begin
         for (int i = 0; i < NR; i++) begin
            if (m_dirty[i]) m_act[i] = m_stg[i];
            m_dirty[i] = 1'b0;
         end
      end
      if (acc) begin
         m_stg[a] = v;
         if (a == LA) m_act[a] = v;
         else         m_dirty[a] = 1'b1;
      end
      @(posedge SCK);
      #1;
      chk("rd_data", IW'(rd_data), IW'(erd));
      chk("wr_err", IW'(wr_err), IW'(we && !acc));
      chk("pending", IW'(pending), IW'(model_pending()));
      chk("cfg_data", cfg_data, model_image());
      chk("parity_err", IW'(parity_err), '0);
      wr_en  = 1'b0;
      commit = 1'b0;
      abort  = 1'b0;
   endtask

   task automatic rd(input int ra, input bit rs);
      step(1'b0, 0, 8'h00, 1'b0, 1'b0, ra, rs);
   endtask

   initial begin
      NRST = 1'b0; wr_en = 1'b0; commit = 1'b0; abort = 1'b0;
      reg_addr = '0; reg_value = '0; rd_addr = '0; rd_stage = 1'b0;
      model_reset();
      #23;
      chk("rst_cfg", cfg_data, RV);
      chk("rst_pending", IW'(pending), '0);
      chk("rst_rd", IW'(rd_data), '0);
      chk("rst_wr_err", IW'(wr_err), '0);
      NRST = 1'b1;
      @(posedge SCK);
      #1;

      // Reset image readback and first staged write / commit
      rd('h23, 1'b0);
      chk("t1_rd_reset", IW'(rd_data), IW'(8'hF8));
      step(1'b1, 'h23, 8'h80, 1'b0, 1'b0, 'h23, 1'b1);
      rd('h23, 1'b1);
      chk("t2_stage", IW'(rd_data), IW'(8'h80));
      rd('h23, 1'b0);
      chk("t2_active_old", IW'(rd_data), IW'(8'hF8));
      chk("t2_pending", IW'(pending), IW'(1'b1));
      step(1'b0, 0, 8'h00, 1'b1, 1'b0, 'h23, 1'b0);
      rd('h23, 1'b0);
      chk("t2_active_new", IW'(rd_data), IW'(8'h80));
      chk("t2_cfg_slice", IW'(cfg_data['h23*DW +: DW]), IW'(8'h80));
      chk("t2_pending_clr", IW'(pending), '0);

      // Abort, then write landing in the same cycle as a commit
      step(1'b1, 'h1B, 8'h10, 1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 0, 8'h00, 1'b0, 1'b1, 0, 1'b0);
      rd('h1B, 1'b1);
      chk("t3_abort_stage", IW'(rd_data), IW'(8'hC0));
      chk("t3_abort_pending", IW'(pending), '0);
      step(1'b1, 'h10, 8'h55, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 'h1B, 8'h66, 1'b1, 1'b0, 0, 1'b0);
      chk("t3_wc_pending", IW'(pending), IW'(1'b1));
      chk("t3_wc_old_commit", IW'(cfg_data['h10*DW +: DW]), IW'(8'h55));
      chk("t3_wc_new_held", IW'(cfg_data['h1B*DW +: DW]), IW'(8'hC0));
      rd('h1B, 1'b1);
      chk("t3_wc_new_stage", IW'(rd_data), IW'(8'h66));
      step(1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0);

      // Read-only and out-of-range rejection, one-cycle error pulse
      step(1'b1, 'h05, 8'hFF, 1'b0, 1'b0, 'h05, 1'b1);
      chk("t4_ro_err", IW'(wr_err), IW'(1'b1));
      rd('h05, 1'b1);
      chk("t4_ro_pulse_end", IW'(wr_err), '0);
      chk("t4_ro_unchanged", IW'(rd_data), IW'(8'h26));
      step(1'b1, 'h3F, 8'h12, 1'b0, 1'b0, 0, 1'b0);
      chk("t4_oor_err", IW'(wr_err), IW'(1'b1));

      // Lock register behaviour
      step(1'b1, LA, 8'h01, 1'b0, 1'b0, 0, 1'b0);
      chk("t5_lock_direct", IW'(cfg_data[LA*DW +: DW]), IW'(8'h01));
      step(1'b1, 'h10, 8'hAA, 1'b0, 1'b0, 0, 1'b0);
      chk("t5_locked_err", IW'(wr_err), IW'(1'b1));
      step(1'b1, LA, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 'h10, 8'hAA, 1'b0, 1'b0, 0, 1'b0);
      chk("t5_unlocked_ok", IW'(wr_err), '0);
      chk("t5_unlocked_pend", IW'(pending), IW'(1'b1));

      // Randomized traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         int a;
         int sel;
         sel = int'($urandom_range(0, 7));
         if (sel == 0)      a = LA;
         else if (sel == 1) a = int'($urandom_range(NR, 63));
         else               a = int'($urandom_range(0, NR - 1));
         step(($urandom % 4) != 0, a, 8'($urandom), ($urandom % 8) == 0,
              ($urandom % 12) == 0, int'($urandom_range(0, 63)), 1'($urandom));
      end

      // Reset in the middle of pending writes
      step(1'b1, LA, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 'h07, 8'h5A, 1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 'h08, 8'hA5, 1'b0, 1'b0, 'h07, 1'b1);
      #2;
      NRST = 1'b0;
      #1;
      chk("t6_rst_cfg", cfg_data, RV);
      chk("t6_rst_pending", IW'(pending), '0);
      chk("t6_rst_rd", IW'(rd_data), '0);
      model_reset();
      @(negedge SCK);
      NRST = 1'b1;
      @(posedge SCK);
      #1;
      rd('h07, 1'b1);
      rd('h08, 1'b1);
      chk("t6_rst_stage", IW'(rd_data), IW'(8'h3B));

`ifdef CFG_PARITY_EN
      force dut.g_cell[3].u_cell.r_active = m_act[3] ^ 8'h01;
      @(posedge SCK);
      #1;
      @(posedge SCK);
      #1;
      chk("t6_parity_set", IW'(parity_err), IW'(1'b1));
      release dut.g_cell[3].u_cell.r_active;
      repeat (3) @(posedge SCK);
      #1;
      chk("t6_parity_sticky", IW'(parity_err), IW'(1'b1));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
